// File: rtl/pc_sched_pkg.sv
// Shared types for the PC sequencing controller: FSM state codes, redirect
// source encoding (numeric order equals priority) and the default address width.
package pc_sched_pkg;

   localparam int REG_SIZE = 32;

   typedef logic [0:0] state_t;
   localparam logic [0:0] ST_RUN  = 1'b0;
   localparam logic [0:0] ST_HALT = 1'b1;

   // Ordered so that a larger code always wins arbitration.
   typedef enum logic [1:0] {
      SRC_NONE = 2'd0,
      SRC_JUMP = 2'd1,
      SRC_BR   = 2'd2,
      SRC_EXC  = 2'd3
   } src_t;

   function automatic logic src_kills_id(input src_t s);
      return (s >= SRC_BR);
   endfunction

endpackage

// File: rtl/pc_sched_if.sv
// Request/response bundle between IF/ID/EX control and the PC scheduler.
// The perf counter signals exist only when PC_SCHED_PERF_EN is defined.
interface pc_sched_if import pc_sched_pkg::*; #(
   parameter int ADDR_W = REG_SIZE,
   parameter int CNT_W  = 16
);
   // Handshake: imem_ready is the fetch "ready"; pc_enable is the fetch "valid"
   // and only rises when imem_ready=1, so a fetch/redirect completes exactly in
   // cycles with pc_enable=1. A redirect not taken stays pending until then.
   logic              imem_ready;
   logic              hazard_stall;
   logic              jump_req;
   logic [ADDR_W-1:0] jump_addr;
   logic              br_req;
   logic [ADDR_W-1:0] br_addr;
   logic              exc_req;
   logic [ADDR_W-1:0] exc_vec;
   logic              halt_req;
   logic              resume;
   logic              pc_enable;
   logic              branch_true;
   logic [ADDR_W-1:0] new_addr;
   logic              flush_if;
   logic              flush_id;
   logic              halted;
   state_t            sched_state;
`ifdef PC_SCHED_PERF_EN
   logic [CNT_W-1:0]  redirect_cnt;
   logic [CNT_W-1:0]  stall_cnt;

   modport master (
      output imem_ready, hazard_stall, jump_req, jump_addr, br_req, br_addr,
             exc_req, exc_vec, halt_req, resume,
      input  pc_enable, branch_true, new_addr, flush_if, flush_id, halted,
             sched_state, redirect_cnt, stall_cnt
   );
   modport slave (
      input  imem_ready, hazard_stall, jump_req, jump_addr, br_req, br_addr,
             exc_req, exc_vec, halt_req, resume,
      output pc_enable, branch_true, new_addr, flush_if, flush_id, halted,
             sched_state, redirect_cnt, stall_cnt
   );
`else
   modport master (
      output imem_ready, hazard_stall, jump_req, jump_addr, br_req, br_addr,
             exc_req, exc_vec, halt_req, resume,
      input  pc_enable, branch_true, new_addr, flush_if, flush_id, halted,
             sched_state
   );
   modport slave (
      input  imem_ready, hazard_stall, jump_req, jump_addr, br_req, br_addr,
             exc_req, exc_vec, halt_req, resume,
      output pc_enable, branch_true, new_addr, flush_if, flush_id, halted,
             sched_state
   );
`endif
endinterface

// File: rtl/pc_sched_redirect_arb.sv
// Combinational redirect arbiter: picks the highest-priority new request and
// decides whether it displaces the pending redirect.
module pc_sched_redirect_arb import pc_sched_pkg::*; #(
   parameter int ADDR_W = REG_SIZE
) (
   input  logic              jump_req,
   input  logic [ADDR_W-1:0] jump_addr,
   input  logic              br_req,
   input  logic [ADDR_W-1:0] br_addr,
   input  logic              exc_req,
   input  logic [ADDR_W-1:0] exc_vec,
   input  logic              pend_vld,
   input  src_t              pend_src,
   input  logic [ADDR_W-1:0] pend_addr,
   output src_t              win_src,
   output logic              accept,
   output logic              redirect_any,
   output logic [ADDR_W-1:0] sel_addr
);
   logic [ADDR_W-1:0] win_addr;

   always_comb begin
      win_src  = SRC_NONE;
      win_addr = '0;
      if (exc_req) begin
         win_src  = SRC_EXC;
         win_addr = exc_vec;
      end else if (br_req) begin
         win_src  = SRC_BR;
         win_addr = br_addr;
      end else if (jump_req) begin
         win_src  = SRC_JUMP;
         win_addr = jump_addr;
      end
      // Equal priority replaces the pending entry; lower priority is dropped.
      accept       = (win_src != SRC_NONE) && (!pend_vld || (win_src >= pend_src));
      redirect_any = accept || pend_vld;
      sel_addr     = accept ? win_addr : pend_addr;
   end

endmodule

// File: rtl/pc_sched.sv
// PC sequencing controller: stall/redirect issue, pending redirect register,
// flush generation and RUN/HALT FSM. Optional counters: PC_SCHED_PERF_EN.
module pc_sched import pc_sched_pkg::*; #(
   parameter int ADDR_W = REG_SIZE,
   parameter int CNT_W  = 16
) (
   input logic       clk,
   input logic       rst,
   pc_sched_if.slave bus
);
   state_t            state, state_nxt;
   logic              pend_vld;
   src_t              pend_src;
   logic [ADDR_W-1:0] pend_addr;
   src_t              win_src;
   logic              accept, redirect_any, issue;
   logic [ADDR_W-1:0] sel_addr;
   logic              pc_enable, branch_true, in_halt;

   pc_sched_redirect_arb #(.ADDR_W(ADDR_W)) u_arb (
      .jump_req     (bus.jump_req),
      .jump_addr    (bus.jump_addr),
      .br_req       (bus.br_req),
      .br_addr      (bus.br_addr),
      .exc_req      (bus.exc_req),
      .exc_vec      (bus.exc_vec),
      .pend_vld     (pend_vld),
      .pend_src     (pend_src),
      .pend_addr    (pend_addr),
      .win_src      (win_src),
      .accept       (accept),
      .redirect_any (redirect_any),
      .sel_addr     (sel_addr)
   );

   always_comb begin
      in_halt   = (state == ST_HALT);
      state_nxt = state;
      // Only an exception may fetch out of HALT; redirects bypass hazard stalls.
      if (in_halt) issue = bus.imem_ready & bus.exc_req;
      else         issue = bus.imem_ready & (redirect_any | ~bus.hazard_stall);
      pc_enable   = rst & issue;
      branch_true = pc_enable & redirect_any;
      if (in_halt) begin
         if (bus.exc_req || bus.resume) state_nxt = ST_RUN;
      end else if (bus.halt_req && !redirect_any) begin
         state_nxt = ST_HALT;
      end
   end

   assign bus.pc_enable   = pc_enable;
   assign bus.branch_true = branch_true;
   assign bus.new_addr    = branch_true ? sel_addr : '0;
   assign bus.flush_if    = rst & accept;
   assign bus.flush_id    = rst & accept & src_kills_id(win_src);
   assign bus.halted      = rst & in_halt & ~bus.exc_req;
   assign bus.sched_state = state;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_RUN;
         pend_vld  <= 1'b0;
         pend_src  <= SRC_NONE;
         pend_addr <= '0;
      end else begin
         state <= state_nxt;
         if (branch_true) begin
            pend_vld <= 1'b0;
            pend_src <= SRC_NONE;
         end else if (accept) begin
            pend_vld  <= 1'b1;
            pend_src  <= win_src;
            pend_addr <= sel_addr;
         end
      end
   end

`ifdef PC_SCHED_PERF_EN
   logic [CNT_W-1:0] redirect_cnt, stall_cnt;

   // Both counters stick at all-ones instead of wrapping.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         redirect_cnt <= '0;
         stall_cnt    <= '0;
      end else begin
         if (branch_true && (redirect_cnt != '1))
            redirect_cnt <= redirect_cnt + 1'b1;
         if (!pc_enable && (state == ST_RUN) && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 1'b1;
      end
   end

   assign bus.redirect_cnt = redirect_cnt;
   assign bus.stall_cnt    = stall_cnt;
`endif

endmodule

// File: tb/tb_pc_sched.sv
// Directed/randomised bench for pc_sched: per-cycle stimulus tables, expected
// output vectors queued when driven and popped when the outputs are sampled.
module tb_pc_sched;
   import pc_sched_pkg::*;

`ifdef PC_SCHED_PERF_EN
   localparam int TB_CNT_W = 4;
`else
   localparam int TB_CNT_W = 16;
`endif

   // Stimulus flag bits: {rst_n, imem_ready, hazard, jump, br, exc, halt, resume}
   localparam logic [7:0] RN = 8'h80, IM = 8'h40, HZ = 8'h20, JP = 8'h10;
   localparam logic [7:0] BQ = 8'h08, EX = 8'h04, HL = 8'h02, RS = 8'h01;

   typedef struct {
      logic [7:0]  f;
      logic [31:0] ja;
      logic [31:0] ba;
      logic [31:0] ev;
      logic [36:0] exp;
   } step_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic [36:0] exp_q[$];
   step_t sq[$];
   logic [36:0] obs, expv;
   int n_cmp = 0;
   int n_err = 0;

   pc_sched_if #(.ADDR_W(32), .CNT_W(TB_CNT_W)) bus();

   pc_sched #(.ADDR_W(32), .CNT_W(TB_CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, compared=%0d", n_cmp);
      $fatal(1, "watchdog");
   end

   // {pc_enable, branch_true, new_addr, flush_if, flush_id, halted}
   function automatic logic [36:0] ex(input logic pe, input logic bt, input logic [31:0] a,
                                      input logic fi, input logic fd, input logic h);
      return {pe, bt, a, fi, fd, h};
   endfunction

   function automatic step_t mk(input logic [7:0] f, input logic [31:0] ja,
                                input logic [31:0] ba, input logic [31:0] ev,
                                input logic [36:0] e);
      step_t s;
      s.f = f; s.ja = ja; s.ba = ba; s.ev = ev; s.exp = e;
      return s;
   endfunction

   task automatic drive(input step_t s);
      @(negedge clk);
      rst              = s.f[7];
      bus.imem_ready   = s.f[6];
      bus.hazard_stall = s.f[5];
      bus.jump_req     = s.f[4];
      bus.br_req       = s.f[3];
      bus.exc_req      = s.f[2];
      bus.halt_req     = s.f[1];
      bus.resume       = s.f[0];
      bus.jump_addr    = s.ja;
      bus.br_addr      = s.ba;
      bus.exc_vec      = s.ev;
      exp_q.push_back(s.exp);
   endtask

   task automatic test_reset();
      sq = {};
      sq.push_back(mk(IM,      0,    0, 0, ex(0, 0, 0, 0, 0, 0)));
      sq.push_back(mk(RN | IM, 0,    0, 0, ex(1, 0, 0, 0, 0, 0)));
      sq.push_back(mk(RN | JP, 'h10, 0, 0, ex(0, 0, 0, 1, 0, 0)));
      sq.push_back(mk(IM | JP, 'h10, 0, 0, ex(0, 0, 0, 0, 0, 0)));
      sq.push_back(mk(RN | IM, 0,    0, 0, ex(1, 0, 0, 0, 0, 0)));
      for (int i = 0; i < sq.size(); i++) begin
         drive(sq[i]);
         #1;
         obs  = {bus.pc_enable, bus.branch_true, bus.new_addr, bus.flush_if, bus.flush_id, bus.halted};
         expv = exp_q.pop_front();
         n_cmp++;
         if (obs !== expv) begin
            n_err++;
            $display("FAIL reset[%0d] got=%h want=%h", i, obs, expv);
         end
      end
   endtask

   task automatic test_stall();
      sq = {};
      sq.push_back(mk(RN | IM | HZ,      0, 0,    0, ex(0, 0, 0,    0, 0, 0)));
      sq.push_back(mk(RN | IM | HZ | BQ, 0, 'h40, 0, ex(1, 1, 'h40, 1, 1, 0)));
      sq.push_back(mk(RN | IM,           0, 0,    0, ex(1, 0, 0,    0, 0, 0)));
      sq.push_back(mk(RN | HZ,           0, 0,    0, ex(0, 0, 0,    0, 0, 0)));
      for (int i = 0; i < sq.size(); i++) begin
         drive(sq[i]);
         #1;
         obs  = {bus.pc_enable, bus.branch_true, bus.new_addr, bus.flush_if, bus.flush_id, bus.halted};
         expv = exp_q.pop_front();
         n_cmp++;
         if (obs !== expv) begin
            n_err++;
            $display("FAIL stall[%0d] got=%h want=%h", i, obs, expv);
         end
      end
   endtask

   task automatic test_pending();
      sq = {};
      sq.push_back(mk(RN | JP,      'h10, 0,    0, ex(0, 0, 0,    1, 0, 0)));
      sq.push_back(mk(RN | BQ,      0,    'h20, 0, ex(0, 0, 0,    1, 1, 0)));
      sq.push_back(mk(RN | JP,      'h50, 0,    0, ex(0, 0, 0,    0, 0, 0)));
      sq.push_back(mk(RN | IM | HZ, 0,    0,    0, ex(1, 1, 'h20, 0, 0, 0)));
      sq.push_back(mk(RN | IM,      0,    0,    0, ex(1, 0, 0,    0, 0, 0)));
      sq.push_back(mk(RN | BQ,      0,    'h60, 0, ex(0, 0, 0,    1, 1, 0)));
      sq.push_back(mk(RN | BQ,      0,    'h70, 0, ex(0, 0, 0,    1, 1, 0)));
      sq.push_back(mk(RN | IM,      0,    0,    0, ex(1, 1, 'h70, 0, 0, 0)));
      for (int i = 0; i < sq.size(); i++) begin
         drive(sq[i]);
         #1;
         obs  = {bus.pc_enable, bus.branch_true, bus.new_addr, bus.flush_if, bus.flush_id, bus.halted};
         expv = exp_q.pop_front();
         n_cmp++;
         if (obs !== expv) begin
            n_err++;
            $display("FAIL pending[%0d] got=%h want=%h", i, obs, expv);
         end
      end
   endtask

   task automatic test_simultaneous();
      sq = {};
      sq.push_back(mk(RN | IM | EX | BQ | JP, 'h10, 'h20, 'h100, ex(1, 1, 'h100, 1, 1, 0)));
      sq.push_back(mk(RN | IM,                0,    0,    0,     ex(1, 0, 0,     0, 0, 0)));
      for (int i = 0; i < sq.size(); i++) begin
         drive(sq[i]);
         #1;
         obs  = {bus.pc_enable, bus.branch_true, bus.new_addr, bus.flush_if, bus.flush_id, bus.halted};
         expv = exp_q.pop_front();
         n_cmp++;
         if (obs !== expv) begin
            n_err++;
            $display("FAIL simultaneous[%0d] got=%h want=%h", i, obs, expv);
         end
      end
   endtask

   task automatic test_halt();
      sq = {};
      sq.push_back(mk(RN | IM | HL, 0, 0, 0, ex(1, 0, 0, 0, 0, 0)));
      for (int k = 0; k < 5; k++)
         sq.push_back(mk(RN | IM, 0, 0, 0, ex(0, 0, 0, 0, 0, 1)));
      sq.push_back(mk(RN | IM | JP, 'h30, 0,    0,     ex(0, 0, 0,     1, 0, 1)));
      sq.push_back(mk(RN | IM | RS, 0,    0,    0,     ex(0, 0, 0,     0, 0, 1)));
      sq.push_back(mk(RN,           0,    0,    0,     ex(0, 0, 0,     0, 0, 0)));
      sq.push_back(mk(RN | IM,      0,    0,    0,     ex(1, 1, 'h30,  0, 0, 0)));
      sq.push_back(mk(RN | IM | HL, 0,    0,    0,     ex(1, 0, 0,     0, 0, 0)));
      sq.push_back(mk(RN | IM,      0,    0,    0,     ex(0, 0, 0,     0, 0, 1)));
      sq.push_back(mk(RN | IM | EX, 0,    0,    'h100, ex(1, 1, 'h100, 1, 1, 0)));
      sq.push_back(mk(RN | IM,      0,    0,    0,     ex(1, 0, 0,     0, 0, 0)));
      sq.push_back(mk(RN | IM | HL | BQ, 0, 'h44, 0,   ex(1, 1, 'h44,  1, 1, 0)));
      sq.push_back(mk(RN | IM | HL, 0,    0,    0,     ex(1, 0, 0,     0, 0, 0)));
      sq.push_back(mk(RN | IM | RS, 0,    0,    0,     ex(0, 0, 0,     0, 0, 1)));
      sq.push_back(mk(RN | IM,      0,    0,    0,     ex(1, 0, 0,     0, 0, 0)));
      for (int i = 0; i < sq.size(); i++) begin
         drive(sq[i]);
         #1;
         obs  = {bus.pc_enable, bus.branch_true, bus.new_addr, bus.flush_if, bus.flush_id, bus.halted};
         expv = exp_q.pop_front();
         n_cmp++;
         if (obs !== expv) begin
            n_err++;
            $display("FAIL halt[%0d] got=%h want=%h", i, obs, expv);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] a;
      logic [7:0]  hz;
      sq = {};
      for (int k = 0; k < 10; k++) begin
         a  = $urandom;
         hz = ($urandom_range(0, 1) == 1) ? HZ : 8'h00;
         if (k % 2 == 0) sq.push_back(mk(RN | IM | hz | BQ, 0, a, 0, ex(1, 1, a, 1, 1, 0)));
         else            sq.push_back(mk(RN | IM | hz | JP, a, 0, 0, ex(1, 1, a, 1, 0, 0)));
      end
      sq.push_back(mk(RN | IM, 0, 0, 0, ex(1, 0, 0, 0, 0, 0)));
      for (int i = 0; i < sq.size(); i++) begin
         drive(sq[i]);
         #1;
         obs  = {bus.pc_enable, bus.branch_true, bus.new_addr, bus.flush_if, bus.flush_id, bus.halted};
         expv = exp_q.pop_front();
         n_cmp++;
         if (obs !== expv) begin
            n_err++;
            $display("FAIL back_to_back[%0d] got=%h want=%h", i, obs, expv);
         end
      end
   endtask

`ifdef PC_SCHED_PERF_EN
   task automatic test_perf();
      logic [31:0] a;
      sq = {};
      sq.push_back(mk(IM, 0, 0, 0, ex(0, 0, 0, 0, 0, 0)));
      for (int k = 0; k < 20; k++) begin
         a = $urandom;
         sq.push_back(mk(RN | IM | BQ, 0, a, 0, ex(1, 1, a, 1, 1, 0)));
      end
      sq.push_back(mk(RN | IM, 0, 0, 0, ex(1, 0, 0, 0, 0, 0)));
      for (int i = 0; i < sq.size(); i++) begin
         drive(sq[i]);
         #1;
         obs  = {bus.pc_enable, bus.branch_true, bus.new_addr, bus.flush_if, bus.flush_id, bus.halted};
         expv = exp_q.pop_front();
         n_cmp++;
         if (obs !== expv) begin
            n_err++;
            $display("FAIL perf_redirect[%0d] got=%h want=%h", i, obs, expv);
         end
      end
      n_cmp++;
      if (bus.redirect_cnt !== 4'hF) begin
         n_err++;
         $display("FAIL redirect_cnt got=%0d want=15", bus.redirect_cnt);
      end
      n_cmp++;
      if (bus.stall_cnt !== 4'd0) begin
         n_err++;
         $display("FAIL stall_cnt_base got=%0d want=0", bus.stall_cnt);
      end
      sq = {};
      for (int k = 0; k < 3; k++)
         sq.push_back(mk(RN | IM | HZ, 0, 0, 0, ex(0, 0, 0, 0, 0, 0)));
      sq.push_back(mk(RN | IM, 0, 0, 0, ex(1, 0, 0, 0, 0, 0)));
      for (int i = 0; i < sq.size(); i++) begin
         drive(sq[i]);
         #1;
         obs  = {bus.pc_enable, bus.branch_true, bus.new_addr, bus.flush_if, bus.flush_id, bus.halted};
         expv = exp_q.pop_front();
         n_cmp++;
         if (obs !== expv) begin
            n_err++;
            $display("FAIL perf_stall[%0d] got=%h want=%h", i, obs, expv);
         end
      end
      n_cmp++;
      if (bus.stall_cnt !== 4'd3) begin
         n_err++;
         $display("FAIL stall_cnt got=%0d want=3", bus.stall_cnt);
      end
   endtask
`endif

   initial begin
      bus.imem_ready   = 1'b0;
      bus.hazard_stall = 1'b0;
      bus.jump_req     = 1'b0;
      bus.br_req       = 1'b0;
      bus.exc_req      = 1'b0;
      bus.halt_req     = 1'b0;
      bus.resume       = 1'b0;
      bus.jump_addr    = '0;
      bus.br_addr      = '0;
      bus.exc_vec      = '0;
      test_reset();
      test_stall();
      test_pending();
      test_simultaneous();
      test_halt();
      test_back_to_back();
`ifdef PC_SCHED_PERF_EN
      test_perf();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pc_sched.md
Name: pc_sched

Overview:
- Sequencing controller for the program counter register: drives its pc_enable, branch_true and new_addr inputs.
- Arbitrates redirect sources (exception, EX branch, ID jump) and stall sources (instruction-memory busy, load-use hazard).
- Holds a redirect in a pending register when it cannot issue immediately, emits pipeline flushes, and supports halt/resume.
- Sits between the IF/ID/EX control logic and the PC register; the PC is word-addressed (+1 per fetch).

Parameters:
- ADDR_W, 32, PC/address width (matches RegSize).
- CNT_W, 16, width of performance counters (optional feature only).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- imem_ready  in  1  instruction memory accepts a fetch this cycle
- hazard_stall  in  1  load-use stall request from ID
- jump_req  in  1  jump redirect from ID
- jump_addr  in  ADDR_W  jump target
- br_req  in  1  taken-branch redirect from EX
- br_addr  in  ADDR_W  branch target
- exc_req  in  1  exception/interrupt redirect
- exc_vec  in  ADDR_W  exception vector
- halt_req  in  1  request to freeze fetch
- resume  in  1  leave HALT
- pc_enable  out  1  to PC register enable
- branch_true  out  1  to PC register load-select
- new_addr  out  ADDR_W  to PC register load value
- flush_if  out  1  kill the IF/ID register
- flush_id  out  1  kill the ID/EX register
- halted  out  1  in HALT state

Behaviour:
- Reset (rst=0, async):
  - State=RUN; pend_vld=0; pend_addr=0; pend_src=NONE.
  - All outputs 0 while reset is held.
- Priority: exc_req > br_req > jump_req > pending. A new request of equal or higher priority than the pending source replaces it; a lower-priority request is ignored while pend_vld=1.
- redirect_any = a new accepted request, or pend_vld; sel_addr = address of the winning source.
- Issue condition:
  - pc_enable = imem_ready & (redirect_any | ~hazard_stall) & state!=HALT. An exception also issues from HALT.
  - Redirects ignore hazard_stall.
- branch_true = pc_enable & redirect_any; new_addr = sel_addr when branch_true, else 0.
- Pending: a request that arrives while imem_ready=0 is latched (pend_vld=1, pend_addr, pend_src). pend_vld clears on the cycle branch_true=1.
- Flush, combinational in the cycle a request is accepted (issued or latched):
  - exc or br: flush_if=1, flush_id=1.
  - jump: flush_if=1 only.
  - An already-pending redirect does not re-flush.
- States:
  - RUN → HALT when halt_req=1 and redirect_any=0 (takes effect next cycle).
  - halt_req together with a redirect: the redirect issues first; HALT is entered the next cycle if halt_req is still 1.
  - HALT: pc_enable=0, halted=1. Redirects other than exc are latched as pending.
  - HALT → RUN on resume=1. A pending redirect then issues on the first cycle with imem_ready=1.
  - HALT → RUN on exc_req=1: issues the vector (subject to imem_ready) and flushes, same cycle.
- Simultaneous exc/br/jump: exc wins; flush_if=flush_id=1; the losing requests are dropped and not latched.
- Reset mid-pending: pending is discarded and no redirect issues after reset.

Optional Feature:
- Macro PC_SCHED_PERF_EN.
- When defined:
  - Adds outputs redirect_cnt[CNT_W] (increments on each branch_true=1) and stall_cnt[CNT_W] (increments each cycle pc_enable=0 in RUN).
  - Both counters saturate at all-ones and reset to 0.
- When undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package (added to port_define):
  - State enum {RUN, HALT}.
  - Source enum {NONE, JUMP, BR, EXC} with ordered encoding so that priority = numeric compare.
  - ADDR_W default tied to RegSize.
- Sub-module redirect_arb: combinational priority select of source and address, with compare against pend_src.
- Pending register and FSM stay in pc_sched.

Test Plan:
1. Reset: rst=0 mid-run with pend_vld=1 → all outputs 0; after release with imem_ready=1 and no requests → pc_enable=1, branch_true=0.
2. Stall: hazard_stall=1, imem_ready=1 → pc_enable=0. Then br_req=1, br_addr=0x40 with hazard_stall=1 → pc_enable=1, branch_true=1, new_addr=0x40, flush_if=flush_id=1.
3. Pending and override:
   - jump_req with jump_addr=0x10 while imem_ready=0 → flush_if=1, flush_id=0, latched.
   - Next cycle br_req with br_addr=0x20 (imem_ready=0) → replaces pending.
   - imem_ready=1 → branch_true=1, new_addr=0x20.
4. Simultaneous requests: exc_req (0x100), br_req (0x20) and jump_req (0x10) in one cycle → new_addr=0x100; the following cycle shows no redirect.
5. Halt:
   - halt_req=1 → halted=1 next cycle, pc_enable=0 for 5 cycles.
   - jump_req (0x30) is latched while halted.
   - resume=1 → the next imem_ready cycle issues new_addr=0x30.
   - A second halt, then exc_req (0x100) → halted=0 and new_addr=0x100 in the same cycle.
6. With PC_SCHED_PERF_EN, CNT_W=4: 20 redirects → redirect_cnt=15 (saturated); a 3-cycle stall → stall_cnt increments by 3.
